// File: rtl/mii_net_rx_fcs.sv
// Receive-side 802.3 frame checker: strips preamble/SFD, checks CRC-32, removes the FCS
// through a 4-byte delay line and reports per-frame status at end of frame.
module mii_net_rx_fcs #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522,
    parameter int LEN_W   = 11
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [7:0]       i_d,
    input  logic             i_d_valid,
    input  logic             i_dv,
    input  logic             i_er,
    output logic [7:0]       o_d,
    output logic             o_d_valid,
    output logic             o_sof,
    output logic             o_eof,
    output logic             o_fcs_ok,
    output logic [3:0]       o_err,
    output logic [LEN_W-1:0] o_len
);

    localparam logic [31:0]      CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0]      CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0]      CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [LEN_W-1:0] LEN_MIN     = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] LEN_MAX     = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT     = '1;

    typedef enum logic [2:0] {
        S_WAIT,
        S_IDLE,
        S_PRE,
        S_DATA,
        S_END,
        S_DROP
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [1:0]       rst_sync;
    logic             rst_n;
    logic             byte_in;
    logic             take;
    logic             start;
    logic             finish;
    logic [31:0]      crc;
    logic [LEN_W-1:0] len;
    logic [7:0]       dline [4];
    logic [2:0]       dl_cnt;
    logic             er_seen;
    logic             sof_pend;
    logic [3:0]       err_now;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // Bit-reversed input byte, MSB-first update: same CRC as the TX generator.
    function automatic logic [31:0] crc_next(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[31] ^ data[i]) begin
                c = {c[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

    assign byte_in = i_d_valid & i_dv;
    assign take    = (state == S_DATA) & byte_in;
    assign err_now = {er_seen, (len > LEN_MAX), (len < LEN_MIN), (crc != CRC_RESIDUE)};

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_WAIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        finish   = 1'b0;
        case (state)
            S_WAIT: begin
                if (!i_dv) begin
                    state_nx = S_IDLE;
                end
            end
            S_IDLE, S_PRE: begin
                if (!i_dv) begin
                    state_nx = S_IDLE;
                end else if (i_d_valid) begin
                    if (i_d == 8'h55) begin
                        state_nx = S_PRE;
                    end else if (i_d == 8'hD5) begin
                        state_nx = S_DATA;
                        start    = 1'b1;
                    end else begin
                        state_nx = S_DROP;
                    end
                end
            end
            S_DATA: begin
                if (!i_dv) begin
                    state_nx = S_END;
                    finish   = 1'b1;
                end
            end
            S_END: begin
                state_nx = S_IDLE;
            end
            S_DROP: begin
                if (!i_dv) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_WAIT;
            end
        endcase
    end

    // Status is registered on the edge that sees RX_DV drop, so o_eof is high during END.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            crc       <= CRC_INIT;
            len       <= '0;
            dl_cnt    <= '0;
            er_seen   <= 1'b0;
            sof_pend  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                dline[i] <= '0;
            end
            o_d       <= '0;
            o_d_valid <= 1'b0;
            o_sof     <= 1'b0;
            o_eof     <= 1'b0;
            o_fcs_ok  <= 1'b0;
            o_err     <= '0;
            o_len     <= '0;
        end else begin
            o_d_valid <= 1'b0;
            o_sof     <= 1'b0;
            o_eof     <= 1'b0;
            o_fcs_ok  <= 1'b0;
            o_err     <= '0;
            o_len     <= '0;

            if (start) begin
                crc      <= CRC_INIT;
                len      <= '0;
                dl_cnt   <= '0;
                er_seen  <= 1'b0;
                sof_pend <= 1'b1;
            end

            if (take) begin
                crc      <= crc_next(crc, i_d);
                len      <= (len == LEN_SAT) ? len : len + 1'b1;
                dline[0] <= dline[1];
                dline[1] <= dline[2];
                dline[2] <= dline[3];
                dline[3] <= i_d;
                if (dl_cnt == 3'd4) begin
                    o_d       <= dline[0];
                    o_d_valid <= 1'b1;
                    o_sof     <= sof_pend;
                    sof_pend  <= 1'b0;
                end else begin
                    dl_cnt <= dl_cnt + 3'd1;
                end
            end

            if ((state == S_DATA) && i_dv && i_er) begin
                er_seen <= 1'b1;
            end

            if (finish) begin
                o_eof    <= 1'b1;
                o_err    <= err_now;
                o_len    <= len;
                o_fcs_ok <= ~|err_now;
                dl_cnt   <= '0;
                sof_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mii_net_rx_fcs.sv
// Scoreboard bench for mii_net_rx_fcs: three instances with different length limits share
// one byte stream; a reflected-form CRC model predicts data and end-of-frame status.
module tb_mii_net_rx_fcs;

    typedef struct packed {
        logic [3:0]  err;
        logic [10:0] len;
    } stat_t;

    logic        clk;
    logic        reset_n;
    logic [7:0]  d;
    logic        d_valid;
    logic        dv;
    logic        er;

    logic [7:0]  a_d, b_d, c_d;
    logic        a_d_valid, b_d_valid, c_d_valid;
    logic        a_sof, b_sof, c_sof;
    logic        a_eof, b_eof, c_eof;
    logic        a_fcs_ok, b_fcs_ok, c_fcs_ok;
    logic [3:0]  a_err, b_err, c_err;
    logic [10:0] a_len, b_len, c_len;

    int          checks;
    int          failures;
    logic [7:0]  frame[$];
    logic [8:0]  dat_a[$];
    stat_t       exp_a[$];
    stat_t       exp_b[$];
    stat_t       exp_c[$];
    logic [8:0]  ed_a;
    stat_t       es_a, es_b, es_c;

    mii_net_rx_fcs #(.MIN_LEN(4), .MAX_LEN(1522), .LEN_W(11)) dut_a (
        .i_clk(clk), .i_reset_n(reset_n), .i_d(d), .i_d_valid(d_valid), .i_dv(dv), .i_er(er),
        .o_d(a_d), .o_d_valid(a_d_valid), .o_sof(a_sof), .o_eof(a_eof),
        .o_fcs_ok(a_fcs_ok), .o_err(a_err), .o_len(a_len)
    );

    mii_net_rx_fcs #(.MIN_LEN(64), .MAX_LEN(1522), .LEN_W(11)) dut_b (
        .i_clk(clk), .i_reset_n(reset_n), .i_d(d), .i_d_valid(d_valid), .i_dv(dv), .i_er(er),
        .o_d(b_d), .o_d_valid(b_d_valid), .o_sof(b_sof), .o_eof(b_eof),
        .o_fcs_ok(b_fcs_ok), .o_err(b_err), .o_len(b_len)
    );

    mii_net_rx_fcs #(.MIN_LEN(4), .MAX_LEN(8), .LEN_W(11)) dut_c (
        .i_clk(clk), .i_reset_n(reset_n), .i_d(d), .i_d_valid(d_valid), .i_dv(dv), .i_er(er),
        .o_d(c_d), .o_d_valid(c_d_valid), .o_sof(c_sof), .o_eof(c_eof),
        .o_fcs_ok(c_fcs_ok), .o_err(c_err), .o_len(c_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] byte_v, input logic dv_v, input logic valid_v,
                                 input logic er_v);
        d       = byte_v;
        dv      = dv_v;
        d_valid = valid_v;
        er      = er_v;
        @(posedge clk);
        #1;
    endtask

    // Reflected CRC-32 over frame[0..n-1]; a frame with a correct FCS leaves DEBB20E3.
    function automatic logic [31:0] crc_refl(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, frame[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return c;
    endfunction

    function automatic stat_t exp_stat(input int n, input int mn, input int mx,
                                       input logic crc_bad, input logic er_v);
        stat_t s;
        s.err = {er_v, (n > mx), (n < mn), crc_bad};
        s.len = 11'(n);
        return s;
    endfunction

    function automatic int pending();
        return dat_a.size() + exp_a.size() + exp_b.size() + exp_c.size();
    endfunction

    task automatic build_check(input logic corrupt);
        frame.delete();
        for (int i = 0; i < 9; i++) begin
            frame.push_back(8'h31 + 8'(i));
        end
        if (corrupt) begin
            frame[4] = 8'h34;
        end
        frame.push_back(8'h26);
        frame.push_back(8'h39);
        frame.push_back(8'hF4);
        frame.push_back(8'hCB);
    endtask

    task automatic build_rand(input int payload);
        logic [31:0] f;
        frame.delete();
        for (int i = 0; i < payload; i++) begin
            frame.push_back(8'($urandom_range(0, 255)));
        end
        f = ~crc_refl(payload);
        frame.push_back(f[7:0]);
        frame.push_back(f[15:8]);
        frame.push_back(f[23:16]);
        frame.push_back(f[31:24]);
    endtask

    // Pushes the predicted results, drives preamble/SFD/frame and one RX_DV-low cycle.
    task automatic send_frame(input int pre, input int er_idx, input logic stall);
        int   n;
        logic crc_bad;
        logic er_v;
        n       = frame.size();
        crc_bad = (crc_refl(n) != 32'hDEBB20E3);
        er_v    = (er_idx >= 0);
        for (int i = 0; i < n - 4; i++) begin
            dat_a.push_back({(i == 0), frame[i]});
        end
        exp_a.push_back(exp_stat(n, 4, 1522, crc_bad, er_v));
        exp_b.push_back(exp_stat(n, 64, 1522, crc_bad, er_v));
        exp_c.push_back(exp_stat(n, 4, 8, crc_bad, er_v));
        for (int i = 0; i < pre; i++) begin
            applyStimulus(8'h55, 1'b1, 1'b1, 1'b0);
        end
        applyStimulus(8'hD5, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) begin
            applyStimulus(frame[i], 1'b1, 1'b1, (i == er_idx));
            if (i >= 4) begin
                @(negedge clk);
                checkOutput("data_latency_valid", 32'(a_d_valid), 32'd1);
                checkOutput("data_latency_byte", 32'(a_d), 32'(frame[i-4]));
            end
            if (stall && i == 6) begin
                applyStimulus(8'hAA, 1'b1, 1'b0, 1'b0);
            end
        end
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("eof_latency", 32'(a_eof), 32'd1);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (pending() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        checkOutput("drain_pending", 32'(pending()), 32'd0);
    endtask

    // Monitors compare DUT output against the scoreboard on the falling edge.
    always @(negedge clk) begin
        if (a_d_valid) begin
            if (dat_a.size() == 0) begin
                checkOutput("a_unexpected_data", 32'(a_d_valid), 32'd0);
            end else begin
                ed_a = dat_a.pop_front();
                checkOutput("a_data", 32'({a_sof, a_d}), 32'(ed_a));
            end
        end else begin
            checkOutput("a_sof_idle", 32'(a_sof), 32'd0);
        end
        if (a_eof) begin
            if (exp_a.size() == 0) begin
                checkOutput("a_unexpected_eof", 32'(a_eof), 32'd0);
            end else begin
                es_a = exp_a.pop_front();
                checkOutput("a_err", 32'(a_err), 32'(es_a.err));
                checkOutput("a_len", 32'(a_len), 32'(es_a.len));
                checkOutput("a_fcs_ok", 32'(a_fcs_ok), 32'(es_a.err == 4'd0));
                checkOutput("a_eof_with_valid", 32'(a_d_valid), 32'd0);
            end
        end else begin
            checkOutput("a_status_idle", 32'({a_fcs_ok, a_err, a_len}), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (b_eof) begin
            if (exp_b.size() == 0) begin
                checkOutput("b_unexpected_eof", 32'(b_eof), 32'd0);
            end else begin
                es_b = exp_b.pop_front();
                checkOutput("b_err", 32'(b_err), 32'(es_b.err));
                checkOutput("b_len", 32'(b_len), 32'(es_b.len));
                checkOutput("b_fcs_ok", 32'(b_fcs_ok), 32'(es_b.err == 4'd0));
            end
        end else begin
            checkOutput("b_status_idle", 32'({b_fcs_ok, b_err, b_len}), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (c_eof) begin
            if (exp_c.size() == 0) begin
                checkOutput("c_unexpected_eof", 32'(c_eof), 32'd0);
            end else begin
                es_c = exp_c.pop_front();
                checkOutput("c_err", 32'(c_err), 32'(es_c.err));
                checkOutput("c_len", 32'(c_len), 32'(es_c.len));
                checkOutput("c_fcs_ok", 32'(c_fcs_ok), 32'(es_c.err == 4'd0));
            end
        end else begin
            checkOutput("c_status_idle", 32'({c_fcs_ok, c_err, c_len}), 32'd0);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired before the directed sequence completed");
        $fatal(1, "[TB] watchdog timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        d        = 8'h00;
        dv       = 1'b0;
        d_valid  = 1'b0;
        er       = 1'b0;
        reset_n  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs_a", 32'({a_d_valid, a_sof, a_eof, a_fcs_ok, a_err, a_len}), 32'd0);
        checkOutput("reset_outputs_c", 32'({c_d_valid, c_sof, c_eof, c_fcs_ok, c_err, c_len}), 32'd0);
        reset_n = 1'b1;
        idle(4);

        $display("[TB] good check frame");
        build_check(1'b0);
        send_frame(7, -1, 1'b0);
        idle(3);
        drain(50);

        $display("[TB] corrupted check frame");
        build_check(1'b1);
        send_frame(7, -1, 1'b0);
        idle(3);
        drain(50);

        $display("[TB] 20-byte frame, short preamble, mid-frame stall");
        build_rand(16);
        send_frame(0, -1, 1'b1);
        idle(3);
        drain(50);

        $display("[TB] length boundaries");
        for (int p = 0; p < 6; p++) begin
            case (p)
                0: build_rand(59);
                1: build_rand(60);
                2: build_rand(4);
                3: build_rand(5);
                4: build_rand(0);
                default: begin
                    frame.delete();
                    frame.push_back(8'hA1);
                    frame.push_back(8'h5C);
                    frame.push_back(8'h07);
                end
            endcase
            send_frame(3, -1, 1'b0);
            idle(2);
            drain(100);
        end

        $display("[TB] bad preamble then a good frame");
        applyStimulus(8'h55, 1'b1, 1'b1, 1'b0);
        applyStimulus(8'h55, 1'b1, 1'b1, 1'b0);
        applyStimulus(8'hA5, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'(i + 8'h40), 1'b1, 1'b1, 1'b0);
        end
        idle(1);
        applyStimulus(8'hD5, 1'b0, 1'b1, 1'b0);
        idle(2);
        build_check(1'b0);
        send_frame(7, -1, 1'b0);
        idle(3);
        drain(50);

        $display("[TB] RX_ER mid-frame");
        build_check(1'b0);
        send_frame(7, 6, 1'b0);
        idle(3);
        drain(50);

        $display("[TB] reset mid-frame");
        build_check(1'b0);
        repeat (7) applyStimulus(8'h55, 1'b1, 1'b1, 1'b0);
        applyStimulus(8'hD5, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(frame[i], 1'b1, 1'b1, 1'b0);
        end
        reset_n = 1'b0;
        applyStimulus(frame[3], 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("reset_mid_outputs", 32'({a_d_valid, a_sof, a_eof, a_fcs_ok, a_err, a_len}), 32'd0);
        reset_n = 1'b1;
        for (int i = 4; i < frame.size(); i++) begin
            applyStimulus(frame[i], 1'b1, 1'b1, 1'b0);
        end
        idle(4);
        drain(10);
        build_check(1'b0);
        send_frame(7, -1, 1'b0);
        idle(3);
        drain(50);

        $display("[TB] back-to-back frames");
        build_check(1'b0);
        send_frame(7, -1, 1'b0);
        send_frame(7, -1, 1'b0);
        idle(3);
        drain(80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
